mips_mdu: RTL

- Parametrised iterative multiply/divide unit owning the HI/LO architectural registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU. It receives rs/rt operands and a decoded MDU op from the control unit.
- Generalises the single-cycle HI/LO write path (wehi/welo) to a WIDTH-bit multicycle engine with start/busy/done handshake, kill on squash, and a stall request for MFHI/MFLO.

---
 rtl/mips_mdu_pkg.sv | 18 +
 rtl/mips_mdu_if.sv | 29 ++
 rtl/mips_mdu_fix.sv | 31 +++
 rtl/mips_mdu.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mips_mdu_pkg.sv
// Shared op codes and FSM state encoding for the MIPS multiply/divide unit.
package mips_mdu_pkg;

   localparam int MDU_MULT  = 0;
   localparam int MDU_MULTU = 1;
   localparam int MDU_DIV   = 2;
   localparam int MDU_DIVU  = 3;
   localparam int MDU_MTHI  = 4;
   localparam int MDU_MTLO  = 5;
   localparam int MDU_NOP   = 7;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } mduState_e;

endpackage

// File: rtl/mips_mdu_if.sv
// Request/response bundle between the EX-stage control and the MDU.
interface mips_mdu_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
);

   logic             start;
   logic [OPW-1:0]   op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             kill;
   logic             rd_req;
   logic             busy;
   logic             done;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, kill, rd_req,
      input  busy, done, stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, kill, rd_req,
      output busy, done, stall, hi, lo
   );

endinterface

// File: rtl/mips_mdu_fix.sv
// Restores result signs: negates the whole product, or quotient and remainder separately.
module mips_mdu_fix #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] res_i,
   input  logic               isDiv_i,
   input  logic               negRes_i,
   input  logic               negRem_i,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // Divide keeps quotient in the low half and remainder in the high half.
   always_comb begin
      prod = negRes_i ? -res_i : res_i;
      quo  = negRes_i ? -res_i[WIDTH-1:0] : res_i[WIDTH-1:0];
      rem  = negRem_i ? -res_i[2*WIDTH-1:WIDTH] : res_i[2*WIDTH-1:WIDTH];
      if (isDiv_i) begin
         hi_o = rem;
         lo_o = quo;
      end else begin
         hi_o = prod[2*WIDTH-1:WIDTH];
         lo_o = prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit owning HI/LO: WIDTH CALC cycles, one FIX cycle
// for sign restore, with kill and an MFHI/MFLO stall request.
module mips_mdu
   import mips_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   mips_mdu_if.slave mdu
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   mduState_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               isDiv_q, isDiv_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic               done_q, done_d;

   logic               reqMul, reqDiv, reqSigned, reqMthi, reqMtlo;
   logic               busy;
   logic [WIDTH-1:0]   aMag, bMag, addend, fixHi, fixLo;
   logic [WIDTH:0]     mulSum, remShift, divDiff;
   logic [2*WIDTH-1:0] mulNext, divNext;

   assign reqMul    = (mdu.op == OPW'(MDU_MULT)) || (mdu.op == OPW'(MDU_MULTU));
   assign reqDiv    = (mdu.op == OPW'(MDU_DIV))  || (mdu.op == OPW'(MDU_DIVU));
   assign reqSigned = (mdu.op == OPW'(MDU_MULT)) || (mdu.op == OPW'(MDU_DIV));
   assign reqMthi   = (mdu.op == OPW'(MDU_MTHI));
   assign reqMtlo   = (mdu.op == OPW'(MDU_MTLO));

   assign aMag = (reqSigned && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
   assign bMag = (reqSigned && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;

   // Multiply: acc holds {partial product, remaining multiplier bits}, shifting right.
   assign addend  = acc_q[0] ? opnd_q : '0;
   assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

   // Divide: acc holds {partial remainder, dividend bits / quotient bits}, shifting left.
   assign remShift = acc_q[2*WIDTH-1:WIDTH-1];
   assign divDiff  = remShift - {1'b0, opnd_q};
   assign divNext  = divDiff[WIDTH] ? {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {divDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

   mips_mdu_fix #(
      .WIDTH(WIDTH)
   ) u_fix (
      .res_i   (acc_q),
      .isDiv_i (isDiv_q),
      .negRes_i(negRes_q),
      .negRem_i(negRem_q),
      .hi_o    (fixHi),
      .lo_o    (fixLo)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         isDiv_q  <= 1'b0;
         negRes_q <= 1'b0;
         negRem_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         isDiv_q  <= isDiv_d;
         negRes_q <= negRes_d;
         negRem_q <= negRem_d;
         done_q   <= done_d;
      end
   end

   // Divide by zero needs no special case: the quotient saturates to all ones and the
   // remainder ends up as |a|, which the remainder sign restore turns back into a.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      isDiv_d  = isDiv_q;
      negRes_d = negRes_q;
      negRem_d = negRem_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (mdu.start && !mdu.kill) begin
               if (reqMul || reqDiv) begin
                  state_d  = CALC;
                  cnt_d    = CNT_INIT;
                  isDiv_d  = reqDiv;
                  opnd_d   = reqDiv ? bMag : aMag;
                  acc_d    = {{WIDTH{1'b0}}, (reqDiv ? aMag : bMag)};
                  negRes_d = reqSigned && (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1])
                             && (reqMul || (mdu.b != '0));
                  negRem_d = reqSigned && reqDiv && mdu.a[WIDTH-1];
               end else if (reqMthi) begin
                  hi_d = mdu.a;
               end else if (reqMtlo) begin
                  lo_d = mdu.a;
               end
            end
         end
         CALC: begin
            if (mdu.kill) begin
               state_d = IDLE;
            end else begin
               acc_d = isDiv_q ? divNext : mulNext;
               if (cnt_q == '0) begin
                  state_d = FIX;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!mdu.kill) begin
               hi_d   = fixHi;
               lo_d   = fixLo;
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign mdu.busy  = busy;
   assign mdu.done  = done_q;
   assign mdu.stall = busy & mdu.rd_req;
   assign mdu.hi    = hi_q;
   assign mdu.lo    = lo_q;

endmodule
